nport_ram: RTL and testbench
============================

NPORT_RAM -- requirements
Module: nport_ram

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16: bits per word; multiple of 8.
REQ-002 SHALL have parameter ADDR_WIDTH, default 7: address bits; depth DEPTH = 2**ADDR_WIDTH.
REQ-003 SHALL have parameter N_RD, default 2: number of synchronous read ports, 1..4.
REQ-004 SHALL have parameter RDW_NEW, default 1: synchronous read-during-write result; 1 = new data, 0 = old data.
REQ-005 SHALL have port clk, input, 1: the single clock; all sequential logic on rising edge.
REQ-006 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-007 SHALL have port we, input, 1: write request.
REQ-008 SHALL have port be, input, DATA_WIDTH/8: byte enables for the write; bit i covers byte i.
REQ-009 SHALL have port add_w, input, ADDR_WIDTH: write address.
REQ-010 SHALL have port data_w, input, DATA_WIDTH: write data.
REQ-011 SHALL have port add_r0, input, ADDR_WIDTH: asynchronous read address.
REQ-012 SHALL have port data_r0, output, DATA_WIDTH: asynchronous read data.
REQ-013 SHALL have port re, input, N_RD: per-port synchronous read enable.
REQ-014 SHALL have port add_r, input, N_RD*ADDR_WIDTH: packed synchronous read addresses; port k at [k*ADDR_WIDTH +: ADDR_WIDTH].
REQ-015 SHALL have port data_r, output, N_RD*DATA_WIDTH: packed registered read data, port k at [k*DATA_WIDTH +: DATA_WIDTH].
REQ-016 SHALL have port rd_valid, output, N_RD: per-port valid, one cycle after an accepted re.
REQ-017 SHALL have port init_done, output, 1: high once memory clearing has completed.

Function
REQ-018 SHALL run a two-state FSM, INIT and READY; reset enters INIT with clear counter at 0.
REQ-019 SHALL, in INIT, write zero to the word at the counter address each cycle and increment the counter; the transition to READY occurs on the cycle the word at address DEPTH-1 is written.
REQ-020 SHALL hold init_done low in INIT and high in READY; INIT lasts exactly DEPTH cycles.
REQ-021 SHALL ignore we and re in INIT; rd_valid stays 0, data_r holds and data_r0 reads 0.
REQ-022 SHALL, in READY with we=1, update only the bytes whose be bit is 1 at add_w on the clock edge; we=1 with be=0 changes nothing.
REQ-023 SHALL present data_r0 = memory[add_r0] combinationally; a write becomes visible after the edge.
REQ-024 SHALL, for port k with re[k]=1 in READY, register memory[add_r k] into data_r k and set rd_valid[k]=1 the next cycle (latency 1); with re[k]=0, rd_valid[k]=0 and data_r k holds.
REQ-025 SHALL, when a sync read and a write hit the same address in the same cycle, return the merged post-write word if RDW_NEW=1, the pre-write word if RDW_NEW=0; unenabled bytes always return old contents.
REQ-026 SHALL allow all N_RD ports to read the same address in one cycle with identical results.

Reset
REQ-027 SHALL, on rst, immediately force data_r=0, rd_valid=0, init_done=0 and the FSM to INIT; asserting rst mid-operation restarts clearing from address 0.

Configuration
REQ-028 SHALL, with NPORT_RAM_PARITY_EN defined, store one even-parity bit per byte, add output par_err (N_RD, registered alongside rd_valid, reset 0) flagging any byte parity mismatch on a valid read; INIT writes correct parity.
REQ-029 SHALL, without NPORT_RAM_PARITY_EN, store no parity bits and have no par_err port.

Structure
REQ-030 SHALL take state encoding (INIT, READY) and the N_RD range constants from shared package mem_pkg.
REQ-031 SHALL place the per-port read register, RDW merge and parity check in one sub-module nport_ram_rd_port, instantiated N_RD times.

Verification (DATA_WIDTH=16, ADDR_WIDTH=4, N_RD=2)
REQ-032 SHALL check: rst pulse -> init_done low 16 cycles then high; every address read 0x0000.
REQ-033 SHALL check: we, be=2'b01, add_w=3, data_w=0xABCD over 0xFFFF -> read add 3 gives 0xFFCD.
REQ-034 SHALL check: write 0x1234 to add 5 while port 0 reads 5 (old 0x0000) -> data_r0-port 0x1234 if RDW_NEW=1, 0x0000 if RDW_NEW=0, rd_valid[0]=1 next cycle.
REQ-035 SHALL check: both ports re=1 at addresses 2 and 2 -> identical data, rd_valid=2'b11; re=0 next -> rd_valid=0, data held.
REQ-036 SHALL check: rst asserted at clear counter 7 -> outputs 0 immediately, clearing restarts, init_done after 16 more cycles.
REQ-037 SHALL check (NPORT_RAM_PARITY_EN): forced single-bit flip in stored word at add 9 -> read of 9 gives par_err=1 for that port.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the multi-port RAM: controller state encoding and
// the supported range of synchronous read ports.
package mem_pkg;

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } ram_state_t;

    localparam int N_RD_MIN = 1;
    localparam int N_RD_MAX = 4;

endpackage

// File: rtl/nport_ram_rd_port.sv
// One synchronous read port: read-during-write merge, output register and,
// when NPORT_RAM_PARITY_EN is defined, per-byte parity check.
module nport_ram_rd_port
    import mem_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 7,
    parameter int RDW_NEW    = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    re,
    input  logic [ADDR_WIDTH-1:0]   add_r,
    input  logic [DATA_WIDTH-1:0]   rd_word,
`ifdef NPORT_RAM_PARITY_EN
    input  logic [DATA_WIDTH/8-1:0] rd_par,
    output logic                    par_err,
`endif
    input  logic                    we,
    input  logic [DATA_WIDTH/8-1:0] be,
    input  logic [ADDR_WIDTH-1:0]   add_w,
    input  logic [DATA_WIDTH-1:0]   data_w,
    output logic [DATA_WIDTH-1:0]   data_r,
    output logic                    rd_valid
);

    localparam int NB = DATA_WIDTH / 8;

    function automatic logic [DATA_WIDTH-1:0] merge_bytes(
        input logic [DATA_WIDTH-1:0] old_w,
        input logic [DATA_WIDTH-1:0] new_w,
        input logic [NB-1:0]         en
    );
        logic [DATA_WIDTH-1:0] m;
        m = old_w;
        for (int b = 0; b < NB; b++)
            if (en[b]) m[b*8 +: 8] = new_w[b*8 +: 8];
        return m;
    endfunction

    logic                  hit;
    logic [DATA_WIDTH-1:0] rd_word_p0;
    logic [DATA_WIDTH-1:0] data_r_p1;
    logic                  vld_p1;

    assign hit = we && (add_w == add_r);

    always_comb begin
        rd_word_p0 = rd_word;
        if ((RDW_NEW != 0) && hit)
            rd_word_p0 = merge_bytes(rd_word, data_w, be);
    end

`ifdef NPORT_RAM_PARITY_EN
    function automatic logic [NB-1:0] par_of(input logic [DATA_WIDTH-1:0] w);
        logic [NB-1:0] p;
        for (int b = 0; b < NB; b++)
            p[b] = ^w[b*8 +: 8];
        return p;
    endfunction

    logic [NB-1:0] rd_par_p0;
    logic          par_err_p1;

    // Bytes taken from the incoming write carry freshly computed parity.
    always_comb begin
        rd_par_p0 = rd_par;
        if ((RDW_NEW != 0) && hit)
            for (int b = 0; b < NB; b++)
                if (be[b]) rd_par_p0[b] = ^data_w[b*8 +: 8];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) par_err_p1 <= 1'b0;
        else     par_err_p1 <= re && (|(par_of(rd_word_p0) ^ rd_par_p0));
    end

    assign par_err = par_err_p1;
`endif

    // ---- p0 -> p1: registered read data and valid ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_r_p1 <= '0;
            vld_p1    <= 1'b0;
        end else begin
            vld_p1 <= re;
            if (re) data_r_p1 <= rd_word_p0;
        end
    end

    assign data_r   = data_r_p1;
    assign rd_valid = vld_p1;

endmodule

// File: rtl/nport_ram.sv
// Byte-writable RAM with one combinational read port, N_RD registered read
// ports and self-clearing after reset. Option: NPORT_RAM_PARITY_EN.
module nport_ram
    import mem_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 7,
    parameter int N_RD       = 2,
    parameter int RDW_NEW    = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         we,
    input  logic [DATA_WIDTH/8-1:0]      be,
    input  logic [ADDR_WIDTH-1:0]        add_w,
    input  logic [DATA_WIDTH-1:0]        data_w,
    input  logic [ADDR_WIDTH-1:0]        add_r0,
    output logic [DATA_WIDTH-1:0]        data_r0,
    input  logic [N_RD-1:0]              re,
    input  logic [N_RD*ADDR_WIDTH-1:0]   add_r,
    output logic [N_RD*DATA_WIDTH-1:0]   data_r,
    output logic [N_RD-1:0]              rd_valid,
`ifdef NPORT_RAM_PARITY_EN
    output logic [N_RD-1:0]              par_err,
`endif
    output logic                         init_done
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int NB    = DATA_WIDTH / 8;

    generate
        if (N_RD < N_RD_MIN || N_RD > N_RD_MAX) begin : g_bad_n_rd
            $error("nport_ram: N_RD out of supported range");
        end
    endgenerate

    ram_state_t            state, state_nxt;
    logic [ADDR_WIDTH-1:0] clr_cnt, clr_cnt_nxt;
    logic                  ready;

    logic                  mem_we;
    logic [NB-1:0]         mem_be;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_data;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_INIT;
            clr_cnt <= '0;
        end else begin
            state   <= state_nxt;
            clr_cnt <= clr_cnt_nxt;
        end
    end

    // Clearing walks every address once; the last one hands over to READY.
    always_comb begin
        state_nxt   = state;
        clr_cnt_nxt = clr_cnt;
        mem_we      = 1'b0;
        mem_be      = be;
        mem_addr    = add_w;
        mem_data    = data_w;
        unique case (state)
            ST_INIT: begin
                mem_we      = 1'b1;
                mem_be      = '1;
                mem_addr    = clr_cnt;
                mem_data    = '0;
                clr_cnt_nxt = clr_cnt + ADDR_WIDTH'(1);
                if (&clr_cnt) state_nxt = ST_READY;
            end
            ST_READY: mem_we = we;
            default:  state_nxt = ST_INIT;
        endcase
    end

    assign ready     = (state == ST_READY);
    assign init_done = ready;

    always_ff @(posedge clk) begin
        if (mem_we)
            for (int b = 0; b < NB; b++)
                if (mem_be[b]) mem[mem_addr][b*8 +: 8] <= mem_data[b*8 +: 8];
    end

`ifdef NPORT_RAM_PARITY_EN
    logic [NB-1:0] par_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (mem_we)
            for (int b = 0; b < NB; b++)
                if (mem_be[b]) par_mem[mem_addr][b] <= ^mem_data[b*8 +: 8];
    end
`endif

    assign data_r0 = ready ? mem[add_r0] : '0;

    generate
        for (genvar k = 0; k < N_RD; k++) begin : g_rd
            logic [ADDR_WIDTH-1:0] port_addr;
            assign port_addr = add_r[k*ADDR_WIDTH +: ADDR_WIDTH];

            nport_ram_rd_port #(
                .DATA_WIDTH (DATA_WIDTH),
                .ADDR_WIDTH (ADDR_WIDTH),
                .RDW_NEW    (RDW_NEW)
            ) u_rd_port (
                .clk      (clk),
                .rst      (rst),
                .re       (re[k] & ready),
                .add_r    (port_addr),
                .rd_word  (mem[port_addr]),
`ifdef NPORT_RAM_PARITY_EN
                .rd_par   (par_mem[port_addr]),
                .par_err  (par_err[k]),
`endif
                .we       (we & ready),
                .be       (be),
                .add_w    (add_w),
                .data_w   (data_w),
                .data_r   (data_r[k*DATA_WIDTH +: DATA_WIDTH]),
                .rd_valid (rd_valid[k])
            );
        end
    endgenerate

endmodule

// File: tb/tb_nport_ram.sv
// Scoreboard bench for nport_ram: directed writes/reads, read-during-write,
// reset restart of clearing, and parity error when NPORT_RAM_PARITY_EN is set.
module tb_nport_ram;

    localparam int DW  = 16;
    localparam int AW  = 4;
    localparam int NR  = 2;
    localparam int RDW = 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             we;
    logic [DW/8-1:0]  be;
    logic [AW-1:0]    add_w;
    logic [DW-1:0]    data_w;
    logic [AW-1:0]    add_r0;
    logic [DW-1:0]    data_r0;
    logic [NR-1:0]    re;
    logic [NR*AW-1:0] add_r;
    logic [NR*DW-1:0] data_r;
    logic [NR-1:0]    rd_valid;
`ifdef NPORT_RAM_PARITY_EN
    logic [NR-1:0]    par_err;
`endif
    logic             init_done;

    nport_ram #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .N_RD(NR), .RDW_NEW(RDW)) dut (
        .clk(clk), .rst(rst), .we(we), .be(be), .add_w(add_w), .data_w(data_w),
        .add_r0(add_r0), .data_r0(data_r0), .re(re), .add_r(add_r),
        .data_r(data_r), .rd_valid(rd_valid),
`ifdef NPORT_RAM_PARITY_EN
        .par_err(par_err),
`endif
        .init_done(init_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          port;
        logic [DW-1:0] data;
        logic        perr;
    } exp_t;

    exp_t scb[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Monitor: every valid read is matched against the oldest expectation.
    always @(negedge clk) begin
        if (!rst) begin
            for (int k = 0; k < NR; k++) begin
                if (rd_valid[k]) begin
                    exp_t e;
                    if (scb.size() == 0 || scb[0].port != k) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_valid port%0d: got data %0h expected no valid", k, data_r[k*DW +: DW]);
                    end else begin
                        e = scb.pop_front();
                        chk($sformatf("rd_port%0d_data", k), 32'(data_r[k*DW +: DW]), 32'(e.data));
`ifdef NPORT_RAM_PARITY_EN
                        chk($sformatf("rd_port%0d_par_err", k), 32'(par_err[k]), 32'(e.perr));
`endif
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int port, input logic [DW-1:0] d, input logic pe);
        exp_t e;
        e.port = port;
        e.data = d;
        e.perr = pe;
        scb.push_back(e);
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [1:0] b);
        we = 1'b1; add_w = a; data_w = d; be = b;
        step();
        we = 1'b0; be = '0;
    endtask

    task automatic rd2(input logic [1:0] en, input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                       input logic [DW-1:0] e0, input logic [DW-1:0] e1, input logic pe0);
        re = en;
        add_r = {a1, a0};
        if (en[0]) push(0, e0, pe0);
        if (en[1]) push(1, e1, 1'b0);
        step();
        re = '0;
    endtask

    task automatic check_init_phase(input string tag);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            add_r0 = AW'(i);
            chk({tag, "_init_low"}, 32'(init_done), 32'h0);
            #1;
            chk({tag, "_init_rd0"}, 32'(data_r0), 32'h0);
        end
        we = 1'b0; re = '0; be = '0;
        @(negedge clk);
        chk({tag, "_init_high"}, 32'(init_done), 32'h1);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish within budget");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; we = 1'b0; be = '0; add_w = '0; data_w = '0;
        add_r0 = '0; re = '0; add_r = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_data_r", data_r, 32'h0);
        chk("rst_rd_valid", 32'(rd_valid), 32'h0);
        chk("rst_init_done", 32'(init_done), 32'h0);

        // Requests during clearing must be ignored.
        we = 1'b1; be = 2'b11; add_w = 4'd0; data_w = 16'hFFFF;
        re = 2'b11; add_r = '0;
        rst = 1'b0;
        check_init_phase("boot");

        for (int a = 0; a < 16; a++) begin
            add_r0 = AW'(a);
            #1;
            chk($sformatf("clear_addr%0d", a), 32'(data_r0), 32'h0);
        end
        step();
        rd2(2'b11, 4'd0, 4'd15, 16'h0000, 16'h0000, 1'b0);

        // Byte-enable merge
        wr(4'd3, 16'hFFFF, 2'b11);
        wr(4'd3, 16'hABCD, 2'b01);
        add_r0 = 4'd3; #1;
        chk("be01_data_r0", 32'(data_r0), 32'hFFCD);
        wr(4'd3, 16'h0000, 2'b00);
        add_r0 = 4'd3; #1;
        chk("be00_nochange", 32'(data_r0), 32'hFFCD);
        rd2(2'b10, 4'd0, 4'd3, 16'h0, 16'hFFCD, 1'b0);

        // Read during write, full word then upper byte only
        we = 1'b1; add_w = 4'd5; data_w = 16'h1234; be = 2'b11;
        re = 2'b01; add_r = {4'd0, 4'd5};
        push(0, (RDW != 0) ? 16'h1234 : 16'h0000, 1'b0);
        step();
        we = 1'b0; re = '0; be = '0;
        add_r0 = 4'd5; #1;
        chk("rdw_after_r0", 32'(data_r0), 32'h1234);

        we = 1'b1; add_w = 4'd5; data_w = 16'h5678; be = 2'b10;
        re = 2'b10; add_r = {4'd5, 4'd0};
        push(1, (RDW != 0) ? 16'h5634 : 16'h1234, 1'b0);
        step();
        we = 1'b0; re = '0; be = '0;
        add_r0 = 4'd5; #1;
        chk("rdw_partial_r0", 32'(data_r0), 32'h5634);

        // Both ports on one address, then hold
        wr(4'd2, 16'hBEEF, 2'b11);
        rd2(2'b11, 4'd2, 4'd2, 16'hBEEF, 16'hBEEF, 1'b0);
        @(negedge clk);
        @(negedge clk);
        chk("hold_rd_valid", 32'(rd_valid), 32'h0);
        chk("hold_data_r", data_r, 32'hBEEFBEEF);

`ifdef NPORT_RAM_PARITY_EN
        step();
        wr(4'd9, 16'h00F0, 2'b11);
        rd2(2'b01, 4'd9, 4'd0, 16'h00F0, 16'h0, 1'b0);
        dut.mem[9] = 16'h00F1;
        rd2(2'b01, 4'd9, 4'd0, 16'h00F1, 16'h0, 1'b1);
        @(negedge clk);
        @(negedge clk);
`endif

        // Asynchronous reset from READY with nonzero outputs
        rst = 1'b1;
        #1;
        chk("arst_data_r", data_r, 32'h0);
        chk("arst_init_done", 32'(init_done), 32'h0);
        rst = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        chk("mid_init_low", 32'(init_done), 32'h0);
        rst = 1'b1;
        #1;
        chk("mid_rst_rd_valid", 32'(rd_valid), 32'h0);
        chk("mid_rst_init_done", 32'(init_done), 32'h0);
        rst = 1'b0;
        check_init_phase("restart");
        add_r0 = 4'd2; #1;
        chk("recleared_addr2", 32'(data_r0), 32'h0);
        step();
        rd2(2'b01, 4'd5, 4'd0, 16'h0000, 16'h0, 1'b0);

        repeat (3) @(negedge clk);
        chk("scb_drain", 32'(scb.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
